branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side partner of the execute-stage branch comparator. Predicts direction and target
//  for the fetch PC from a direct-mapped table (tag, target, 2-bit saturating counter) and
//  is trained by the resolved branch decision from execute.
//  On a wrong prediction it issues a registered redirect to the PC mux one cycle after resolve.
// PARAMETERS
//  ENTRIES   64     table depth, power of two >= 4; IDX_W = $clog2(ENTRIES)
//  CTR_INIT  2'b01  counter value after reset and on not-taken allocation (weakly not-taken)
// PORTS
//  clk               in   1   single clock, rising edge
//  rst_n             in   1   asynchronous reset, active low
//  lookup_pc         in   32  fetch PC, word aligned; bits [1:0] ignored
//  pred_taken        out  1   predict taken: hit && ctr[1]
//  pred_target       out  32  hit && ctr[1] ? stored target : lookup_pc + 4
//  pred_hit          out  1   valid entry with matching tag
//  upd_valid         in   1   one resolved control-flow instruction this cycle
//  upd_pc            in   32  PC of resolved instruction
//  upd_taken         in   1   comparator branch output (actual direction)
//  upd_uncond        in   1   jump (condition code 3'b011); forces strongly-taken training
//  upd_target        in   32  computed target from execute
//  upd_pred_taken    in   1   prediction carried down the pipe with this instruction
//  upd_pred_target   in   32  predicted target carried down the pipe
//  mispredict        out  1   registered; 1-cycle pulse
//  redirect_pc       out  32  registered; correct next PC, valid while mispredict = 1
//  branch_count      out  32  resolved updates, wraps at 2^32
//  mispredict_count  out  32  mispredictions, wraps at 2^32
// BEHAVIOUR
//  Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
//  Lookup: combinational from registered table state; no handshake, always valid.
//  Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturates at 00/11.
//  Update (on clk edge when upd_valid):
//   - miss (invalid or tag mismatch): allocate: valid=1, tag, target=upd_target,
//     ctr = upd_uncond ? 11 : (upd_taken ? 10 : CTR_INIT). Replace unconditionally.
//   - hit: upd_uncond -> ctr=11; else taken -> ctr+1 sat, not-taken -> ctr-1 sat.
//     Target overwritten only when upd_taken = 1.
//  Mispredict check (same cycle as update, result registered):
//   actual = upd_taken ? upd_target : upd_pc+4
//   predicted = upd_pred_taken ? upd_pred_target : upd_pc+4
//   next cycle: mispredict = upd_valid && (actual != predicted); redirect_pc = actual.
//   Covers right direction / wrong target. Latency from upd_valid to mispredict: 1 cycle.
//  upd_valid = 0: table unchanged; mispredict = 0 next cycle; redirect_pc holds last value.
//  Counters: branch_count += 1 per upd_valid; mispredict_count += 1 per mispredict
//   condition, incremented on the same edge that registers mispredict.
//  Simultaneous lookup and update to same index: lookup returns pre-update state (no bypass).
//  Adjacent updates: back-to-back updates on consecutive cycles are each fully applied.
//  Adder overflow: pc+4 wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
//  Reset (async assert, sync-safe deassert): all valid=0, ctr=CTR_INIT, tag/target=0;
//   mispredict=0, redirect_pc=0, both counts=0. Reset mid-update drops the update.
//  Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
// STRUCTURE
//  Shared package riscv_bp_pkg: counter encodings (CTR_SNT/WNT/WT/ST), PC_INC = 32'd4,
//   entry struct typedef, branch condition codes shared with the comparator (3'b011 = jump).
//  Sub-module sat_counter2: 2-bit next-state function (taken, force_st) -> next ctr.
//  Table in flops (ENTRIES small); no memory macro. No other hierarchy.
// TESTING
//  1 Reset, lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; counts = 0.
//  2 Update pc=0x100 taken, target 0x200, pred NT -> next cycle mispredict=1,
//    redirect_pc=0x200; lookup 0x100 -> hit, ctr=10, pred_taken=1, pred_target=0x200.
//  3 Four NT updates at 0x100 from ctr=11 -> ctr 10,01,00,00; pred_taken=0 after second.
//  4 Alias: update 0x100 then 0x100+4*ENTRIES (same index) -> tag replaced; lookup 0x100 misses.
//  5 Same-cycle lookup/update at 0x100 -> lookup sees old ctr; next cycle sees new.
//  6 Pred taken to 0x300, actual taken to 0x340 -> mispredict=1, redirect 0x340,
//    mispredict_count+1; assert rst_n low mid-stream -> all outputs reset immediately.

Source files
------------

// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor/comparator definitions: counter encodings, PC step, table entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam logic [31:0] PC_INC = 32'd4;

    // Condition codes shared with the execute-stage comparator.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_JUMP = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Tag is held right-justified in a field wide enough for the smallest table.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute training and redirect signals between pipeline and predictor.
// Latency: n/a (wiring only).
// Backpressure: none; lookup is always valid, updates are accepted every cycle.
interface branch_predictor_if;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_uncond;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_uncond, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, pred_hit, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_uncond, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, pred_hit, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state (00 strong-NT .. 11 strong-T).
// Latency: combinational.
// Backpressure: none.
module sat_counter2
    import riscv_bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    input  logic force_st,
    output ctr_t ctr_nxt
);
    always_comb begin
        ctr_nxt = ctr;
        if (force_st) begin
            ctr_nxt = CTR_ST;
        end else if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped direction/target predictor trained by execute; registered redirect on mispredict.
// Latency: lookup combinational; mispredict/redirect 1 cycle after upd_valid.
// Backpressure: none; one update accepted every cycle.
module branch_predictor
    import riscv_bp_pkg::*;
#(
    parameter int   ENTRIES  = 64,
    parameter ctr_t CTR_INIT = CTR_WNT
) (
    input  logic clk,
    input  logic rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    bp_entry_t table_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    bp_entry_t        lk_e, up_e;
    logic             up_hit;
    ctr_t             hit_ctr, alloc_ctr;
    logic [31:0]      upd_seq_pc, actual_pc, predicted_pc;
    logic             wrong;

    logic        mispredict_q;
    logic [31:0] redirect_q, branch_cnt_q, misp_cnt_q;

    assign lk_idx = bp.lookup_pc[IDX_W+1:2];
    assign lk_tag = bp.lookup_pc[31:IDX_W+2];
    assign up_idx = bp.upd_pc[IDX_W+1:2];
    assign up_tag = bp.upd_pc[31:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign lk_e           = table_q[lk_idx];
    assign bp.pred_hit    = lk_e.valid && (lk_e.tag == 30'(lk_tag));
    assign bp.pred_taken  = bp.pred_hit && lk_e.ctr[1];
    assign bp.pred_target = bp.pred_taken ? lk_e.target : bp.lookup_pc + PC_INC;

    assign up_e   = table_q[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == 30'(up_tag));

    sat_counter2 u_ctr (
        .ctr      (up_e.ctr),
        .taken    (bp.upd_taken),
        .force_st (bp.upd_uncond),
        .ctr_nxt  (hit_ctr)
    );

    assign alloc_ctr = bp.upd_uncond ? CTR_ST : (bp.upd_taken ? CTR_WT : CTR_INIT);

    // A right-direction, wrong-target prediction also counts as a mispredict.
    assign upd_seq_pc   = bp.upd_pc + PC_INC;
    assign actual_pc    = bp.upd_taken ? bp.upd_target : upd_seq_pc;
    assign predicted_pc = bp.upd_pred_taken ? bp.upd_pred_target : upd_seq_pc;
    assign wrong        = bp.upd_valid && (actual_pc != predicted_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else begin
            mispredict_q <= wrong;
            if (wrong) misp_cnt_q <= misp_cnt_q + 32'd1;
            if (bp.upd_valid) begin
                redirect_q   <= actual_pc;
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (up_hit) begin
                    table_q[up_idx].ctr <= hit_ctr;
                    if (bp.upd_taken) table_q[up_idx].target <= bp.upd_target;
                end else begin
                    table_q[up_idx] <= '{valid: 1'b1, tag: 30'(up_tag),
                                         target: bp.upd_target, ctr: alloc_ctr};
                end
            end
        end
    end

    assign bp.mispredict       = mispredict_q;
    assign bp.redirect_pc      = redirect_q;
    assign bp.branch_count     = branch_cnt_q;
    assign bp.mispredict_count = misp_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector-table bench for branch_predictor (ENTRIES=64, CTR_INIT=01).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if bpi ();

    branch_predictor #(.ENTRIES(64), .CTR_INIT(2'b01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bpi)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_bc = 0;
    logic [31:0] exp_mc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bpi.upd_valid       = 1'b0;
        bpi.upd_pc          = '0;
        bpi.upd_taken       = 1'b0;
        bpi.upd_uncond      = 1'b0;
        bpi.upd_target      = '0;
        bpi.upd_pred_taken  = 1'b0;
        bpi.upd_pred_target = '0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        tk;
        logic        un;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [31:0] lk;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_misp;
        logic [31:0] e_redir;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        //           v  pc            tk un tgt           ptk ptgt     lk            hit tk e_tgt         misp redir
        vecs[0]  = '{1, 32'h100,      1, 0, 32'h200,      0, 32'h0,    32'h100,      1, 1, 32'h200,      1, 32'h200};
        vecs[1]  = '{1, 32'h100,      1, 0, 32'h200,      1, 32'h200,  32'h100,      1, 1, 32'h200,      0, 32'h200};
        vecs[2]  = '{1, 32'h100,      0, 0, 32'h200,      1, 32'h200,  32'h100,      1, 1, 32'h200,      1, 32'h104};
        vecs[3]  = '{1, 32'h100,      0, 0, 32'h200,      1, 32'h200,  32'h100,      1, 0, 32'h104,      1, 32'h104};
        vecs[4]  = '{1, 32'h100,      0, 0, 32'h200,      0, 32'h0,    32'h100,      1, 0, 32'h104,      0, 32'h104};
        vecs[5]  = '{1, 32'h100,      0, 0, 32'h200,      0, 32'h0,    32'h100,      1, 0, 32'h104,      0, 32'h104};
        vecs[6]  = '{1, 32'h100,      1, 0, 32'h280,      0, 32'h0,    32'h100,      1, 0, 32'h104,      1, 32'h280};
        vecs[7]  = '{1, 32'h100,      1, 0, 32'h280,      0, 32'h0,    32'h100,      1, 1, 32'h280,      1, 32'h280};
        vecs[8]  = '{0, 32'h100,      1, 0, 32'h999,      0, 32'h0,    32'h100,      1, 1, 32'h280,      0, 32'h280};
        vecs[9]  = '{1, 32'h200,      0, 0, 32'h900,      0, 32'h0,    32'h100,      0, 0, 32'h104,      0, 32'h204};
        vecs[10] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h0,    32'h200,      1, 0, 32'h204,      0, 32'h204};
        vecs[11] = '{1, 32'h40,       1, 1, 32'h1000,     0, 32'h0,    32'h40,       1, 1, 32'h1000,     1, 32'h1000};
        vecs[12] = '{1, 32'h40,       0, 0, 32'h2222,     1, 32'h1000, 32'h40,       1, 1, 32'h1000,     1, 32'h44};
        vecs[13] = '{1, 32'h80,       1, 0, 32'h300,      0, 32'h0,    32'h80,       1, 1, 32'h300,      1, 32'h300};
        vecs[14] = '{1, 32'h80,       1, 0, 32'h340,      1, 32'h300,  32'h80,       1, 1, 32'h340,      1, 32'h340};
        vecs[15] = '{1, 32'hFFFF_FFFC, 0, 0, 32'h500,     0, 32'h0,    32'hFFFF_FFFC, 1, 0, 32'h0,       0, 32'h0};
    end

    initial begin
        idle_inputs();
        bpi.lookup_pc = 32'h100;
        #12;
        chk("rst_hit",    {31'b0, bpi.pred_hit},   32'd0);
        chk("rst_taken",  {31'b0, bpi.pred_taken}, 32'd0);
        chk("rst_target", bpi.pred_target,         32'h104);
        chk("rst_misp",   {31'b0, bpi.mispredict}, 32'd0);
        chk("rst_redir",  bpi.redirect_pc,         32'd0);
        chk("rst_bc",     bpi.branch_count,        32'd0);
        chk("rst_mc",     bpi.mispredict_count,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bpi.upd_valid       = vecs[i].v;
            bpi.upd_pc          = vecs[i].pc;
            bpi.upd_taken       = vecs[i].tk;
            bpi.upd_uncond      = vecs[i].un;
            bpi.upd_target      = vecs[i].tgt;
            bpi.upd_pred_taken  = vecs[i].ptk;
            bpi.upd_pred_target = vecs[i].ptgt;
            bpi.lookup_pc       = vecs[i].lk;
            @(posedge clk);
            #1;
            if (vecs[i].v) exp_bc = exp_bc + 1;
            if (vecs[i].e_misp) exp_mc = exp_mc + 1;
            chk($sformatf("v%0d_hit", i),    {31'b0, bpi.pred_hit},   {31'b0, vecs[i].e_hit});
            chk($sformatf("v%0d_taken", i),  {31'b0, bpi.pred_taken}, {31'b0, vecs[i].e_tk});
            chk($sformatf("v%0d_target", i), bpi.pred_target,         vecs[i].e_tgt);
            chk($sformatf("v%0d_misp", i),   {31'b0, bpi.mispredict}, {31'b0, vecs[i].e_misp});
            chk($sformatf("v%0d_redir", i),  bpi.redirect_pc,         vecs[i].e_redir);
            chk($sformatf("v%0d_bc", i),     bpi.branch_count,        exp_bc);
            chk($sformatf("v%0d_mc", i),     bpi.mispredict_count,    exp_mc);
        end

        // Same-cycle lookup and update at 0x40 (ctr=10): lookup sees old state until the edge.
        @(negedge clk);
        idle_inputs();
        bpi.upd_valid       = 1'b1;
        bpi.upd_pc          = 32'h40;
        bpi.upd_taken       = 1'b0;
        bpi.upd_pred_taken  = 1'b1;
        bpi.upd_pred_target = 32'h1000;
        bpi.lookup_pc       = 32'h40;
        #1;
        chk("byp_old_taken",  {31'b0, bpi.pred_taken}, 32'd1);
        chk("byp_old_target", bpi.pred_target,         32'h1000);
        @(posedge clk);
        #1;
        exp_bc = exp_bc + 1;
        exp_mc = exp_mc + 1;
        chk("byp_new_taken",  {31'b0, bpi.pred_taken}, 32'd0);
        chk("byp_new_target", bpi.pred_target,         32'h44);
        chk("byp_misp",       {31'b0, bpi.mispredict}, 32'd1);
        chk("byp_mc",         bpi.mispredict_count,    exp_mc);

        // Idle cycle: pulse drops, redirect holds.
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("idle_misp",  {31'b0, bpi.mispredict}, 32'd0);
        chk("idle_redir", bpi.redirect_pc,         32'h44);
        chk("idle_bc",    bpi.branch_count,        exp_bc);

        // Wrong target with right direction, then asynchronous reset while the pulse is high.
        @(negedge clk);
        bpi.upd_valid       = 1'b1;
        bpi.upd_pc          = 32'h80;
        bpi.upd_taken       = 1'b1;
        bpi.upd_target      = 32'h3C0;
        bpi.upd_pred_taken  = 1'b1;
        bpi.upd_pred_target = 32'h340;
        bpi.lookup_pc       = 32'h80;
        @(posedge clk);
        #1;
        exp_mc = exp_mc + 1;
        chk("wt_misp",  {31'b0, bpi.mispredict}, 32'd1);
        chk("wt_redir", bpi.redirect_pc,         32'h3C0);
        chk("wt_mc",    bpi.mispredict_count,    exp_mc);
        bpi.upd_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_misp",   {31'b0, bpi.mispredict}, 32'd0);
        chk("arst_redir",  bpi.redirect_pc,         32'd0);
        chk("arst_bc",     bpi.branch_count,        32'd0);
        chk("arst_mc",     bpi.mispredict_count,    32'd0);
        chk("arst_hit",    {31'b0, bpi.pred_hit},   32'd0);
        chk("arst_target", bpi.pred_target,         32'h84);

        // Update presented while reset is held across the edge must be dropped.
        bpi.upd_valid  = 1'b1;
        bpi.upd_pc     = 32'h80;
        bpi.upd_taken  = 1'b1;
        bpi.upd_target = 32'h700;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("drop_hit", {31'b0, bpi.pred_hit}, 32'd0);
        chk("drop_bc",  bpi.branch_count,      32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
